// File: rtl/axi_common_pkg.sv
// rtl/axi_common_pkg.sv - shared AXI response codes and response type
package axi_common;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_channel.sv
// rtl/axi_lite_channel.sv - AXI-Lite channel bundle with responder modport
interface axi_lite_channel
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rstn
);

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  resp_t                   b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;

  // The responder runs on its own clock/reset, so clk/rstn are not part of it.
  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axi_lite_strb_merge.sv
// rtl/axi_lite_strb_merge.sv - byte-strobe merge of a new word into an old word
module axi_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Take each byte from the new word only where its strobe is set.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < DATA_WIDTH/8; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI-Lite register file; AXI_LITE_REGFILE_DECERR_EN enables DECERR for out-of-range accesses
module axi_lite_regfile
  import axi_common::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter              RESET_VALUE = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  axi_lite_channel.slave                       master,
  output logic [NUM_REGS*master.DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                  wr_pulse
);

  localparam int DW  = master.DATA_WIDTH;
  localparam int AW  = master.ADDR_WIDTH;
  localparam int OFS = $clog2(DW/8);

`ifdef AXI_LITE_REGFILE_DECERR_EN
  localparam resp_t OOR_RESP = RESP_DECERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  logic            aw_held;
  logic            w_held;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [DW/8-1:0] w_strb_q;
  logic            b_valid_q;
  resp_t           b_resp_q;
  logic            r_valid_q;
  logic [DW-1:0]   r_data_q;
  resp_t           r_resp_q;
  logic [DW-1:0]   regs [NUM_REGS];

  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            wr_in_range;
  logic            rd_in_range;
  logic            commit;
  logic [DW-1:0]   wr_old;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   merged;

  assign wr_idx      = aw_addr_q >> OFS;
  assign rd_idx      = master.ar_addr >> OFS;
  assign wr_in_range = wr_idx < AW'(NUM_REGS);
  assign rd_in_range = rd_idx < AW'(NUM_REGS);
  // A write may only commit once its previous response has been taken.
  assign commit      = aw_held && w_held && !b_valid_q;

  assign master.aw_ready = !aw_held;
  assign master.w_ready  = !w_held;
  assign master.b_valid  = b_valid_q;
  assign master.b_resp   = b_resp_q;
  assign master.ar_ready = !r_valid_q;
  assign master.r_valid  = r_valid_q;
  assign master.r_data   = r_data_q;
  assign master.r_resp   = r_resp_q;

  // Select the word being merged and the word being read.
  always_comb begin
    wr_old  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == AW'(i)) wr_old = regs[i];
      if (rd_idx == AW'(i)) rd_word = regs[i];
    end
  end

  axi_lite_strb_merge #(.DATA_WIDTH(DW)) u_merge (
    .old_word (wr_old),
    .new_word (w_data_q),
    .strb     (w_strb_q),
    .merged   (merged)
  );

  // One-entry AW and W holds, filled independently and emptied together by a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
      end else if (master.aw_valid && !aw_held) begin
        aw_held   <= 1'b1;
        aw_addr_q <= master.aw_addr;
      end
      if (commit) begin
        w_held <= 1'b0;
      end else if (master.w_valid && !w_held) begin
        w_held   <= 1'b1;
        w_data_q <= master.w_data;
        w_strb_q <= master.w_strb;
      end
    end
  end

  // Write response: raised by a commit, held until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else if (commit) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= wr_in_range ? RESP_OKAY : OOR_RESP;
    end else if (b_valid_q && master.b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  // Register array update and per-register write strobe; out-of-range commits touch nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DW'(RESET_VALUE);
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_in_range && wr_idx == AW'(i)) begin
          regs[i]     <= merged;
          wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  // Read channel: capture the pre-write register value on AR, hold it until R is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (master.ar_valid && !r_valid_q) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_in_range ? rd_word : '0;
      r_resp_q  <= rd_in_range ? RESP_OKAY : OOR_RESP;
    end else if (r_valid_q && master.r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - randomized self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;
  import axi_common::*;

  localparam int          NR = 16;
  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;
`ifdef AXI_LITE_REGFILE_DECERR_EN
  localparam resp_t OOR = RESP_DECERR;
`else
  localparam resp_t OOR = RESP_OKAY;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    wr_pulse;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus (.clk(clk), .rstn(~rst));

  axi_lite_regfile #(.NUM_REGS(NR), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .master   (bus),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   model [NR];
  logic [NR-1:0] pulse_seen;
  int            pulse_cycles;

  function automatic void model_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    int idx = int'(addr / 4);
    if (idx < NR)
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    return (addr / 4 < NR) ? model[addr / 4] : 32'h0;
  endfunction

  function automatic resp_t model_resp(logic [31:0] addr);
    return (addr / 4 < NR) ? RESP_OKAY : OOR;
  endfunction

  function automatic logic [NR-1:0] model_pulse(logic [31:0] addr);
    logic [NR-1:0] p = '0;
    if (addr / 4 < NR) p[addr / 4] = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_pulse != '0) begin
      pulse_seen |= wr_pulse;
      pulse_cycles++;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output resp_t resp, output bit ok);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    pulse_seen = '0; pulse_cycles = 0;
    bus.aw_valid = 1; bus.aw_addr = addr;
    bus.w_valid = 1; bus.w_data = data; bus.w_strb = strb;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.aw_valid && bus.aw_ready;
      w_hs  = bus.w_valid && bus.w_ready;
      step(); n++;
      if (aw_hs) begin aw_done = 1; bus.aw_valid = 0; end
      if (w_hs) begin w_done = 1; bus.w_valid = 0; end
    end
    bus.aw_valid = 0; bus.w_valid = 0;
    n = 0;
    while (!bus.b_valid && n < 20) begin step(); n++; end
    ok = aw_done && w_done && bus.b_valid;
    resp = bus.b_resp;
    bus.b_ready = 1; step(); bus.b_ready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output resp_t resp,
                         output bit ok);
    int n = 0;
    bus.ar_valid = 1; bus.ar_addr = addr;
    while (!bus.ar_ready && n < 20) begin step(); n++; end
    step(); bus.ar_valid = 0;
    n = 0;
    while (!bus.r_valid && n < 20) begin step(); n++; end
    ok = bus.r_valid; data = bus.r_data; resp = bus.r_resp;
    bus.r_ready = 1; step(); bus.r_ready = 0;
  endtask

  task automatic test_reset();
    int bad = 0;
    tests++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b111) begin
      fails++; $display("FAIL reset_ready: got %b expected 111", {bus.aw_ready, bus.w_ready, bus.ar_ready});
    end
    tests++;
    if ({bus.b_valid, bus.r_valid} !== 2'b00 || bus.b_resp !== RESP_OKAY || bus.r_resp !== RESP_OKAY) begin
      fails++; $display("FAIL reset_valid_resp: got bv=%b rv=%b br=%0d rr=%0d expected 0 0 0 0",
                        bus.b_valid, bus.r_valid, bus.b_resp, bus.r_resp);
    end
    tests++;
    if (bus.r_data !== 32'h0 || wr_pulse !== '0) begin
      fails++; $display("FAIL reset_rdata_pulse: got %h/%h expected 0/0", bus.r_data, wr_pulse);
    end
    for (int i = 0; i < NR; i++) if (reg_q[i*DW +: DW] !== model[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_regs: %0d regs differ from %h", bad, RV); end
  endtask

  task automatic test_same_cycle();
    bus.aw_valid = 1; bus.aw_addr = 32'h8;
    bus.w_valid = 1; bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF; bus.b_ready = 0;
    step();
    bus.aw_valid = 0; bus.w_valid = 0;
    tests++;
    if (bus.b_valid !== 1'b0) begin fails++; $display("FAIL same_b_early: got %b expected 0", bus.b_valid); end
    step();
    model_write(32'h8, 32'hDEADBEEF, 4'hF);
    tests++;
    if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY) begin
      fails++; $display("FAIL same_b_latency: got bv=%b resp=%0d expected 1 0", bus.b_valid, bus.b_resp);
    end
    tests++;
    if (reg_q[2*DW +: DW] !== model[2]) begin
      fails++; $display("FAIL same_reg2: got %h expected %h", reg_q[2*DW +: DW], model[2]);
    end
    tests++;
    if (wr_pulse !== model_pulse(32'h8)) begin
      fails++; $display("FAIL same_pulse: got %h expected %h", wr_pulse, model_pulse(32'h8));
    end
    step();
    tests++;
    if (wr_pulse !== '0 || bus.b_valid !== 1'b1) begin
      fails++; $display("FAIL same_hold: got pulse=%h bv=%b expected 0 1", wr_pulse, bus.b_valid);
    end
    bus.b_ready = 1; step(); bus.b_ready = 0;
    tests++;
    if (bus.b_valid !== 1'b0) begin fails++; $display("FAIL same_b_clear: got %b expected 0", bus.b_valid); end
  endtask

  task automatic test_w_first();
    resp_t resp; bit ok; int n = 0;
    do_write(32'h0, 32'h0, 4'hF, resp, ok);
    model_write(32'h0, 32'h0, 4'hF);
    bus.w_valid = 1; bus.w_data = 32'h11223344; bus.w_strb = 4'h5;
    step();
    bus.w_valid = 0;
    repeat (3) begin
      tests++;
      if (bus.b_valid !== 1'b0 || bus.w_ready !== 1'b0 || reg_q[0 +: DW] !== model[0]) begin
        fails++; $display("FAIL wfirst_wait: got bv=%b wr=%b reg0=%h expected 0 0 %h",
                          bus.b_valid, bus.w_ready, reg_q[0 +: DW], model[0]);
      end
      step();
    end
    bus.aw_valid = 1; bus.aw_addr = 32'h0;
    step();
    bus.aw_valid = 0;
    while (!bus.b_valid && n < 10) begin step(); n++; end
    model_write(32'h0, 32'h11223344, 4'h5);
    tests++;
    if (bus.b_valid !== 1'b1 || bus.b_resp !== RESP_OKAY || reg_q[0 +: DW] !== model[0]) begin
      fails++; $display("FAIL wfirst_commit: got bv=%b resp=%0d reg0=%h expected 1 0 %h",
                        bus.b_valid, bus.b_resp, reg_q[0 +: DW], model[0]);
    end
    bus.b_ready = 1; step(); bus.b_ready = 0;
  endtask

  task automatic test_b_stall();
    logic [31:0] d1 = $urandom, d2 = $urandom;
    bus.b_ready = 0;
    bus.aw_valid = 1; bus.aw_addr = 32'hC; bus.w_valid = 1; bus.w_data = d1; bus.w_strb = 4'hF;
    step();
    bus.aw_valid = 0; bus.w_valid = 0;
    step();
    model_write(32'hC, d1, 4'hF);
    bus.ar_valid = 1; bus.ar_addr = 32'h8;
    tests++;
    if (bus.ar_ready !== 1'b1 || bus.b_valid !== 1'b1) begin
      fails++; $display("FAIL bstall_ar_ready: got ar=%b bv=%b expected 1 1", bus.ar_ready, bus.b_valid);
    end
    step();
    bus.ar_valid = 0;
    tests++;
    if (bus.r_valid !== 1'b1 || bus.r_data !== model[2]) begin
      fails++; $display("FAIL bstall_read: got rv=%b data=%h expected 1 %h", bus.r_valid, bus.r_data, model[2]);
    end
    bus.r_ready = 1; step(); bus.r_ready = 0;
    bus.aw_valid = 1; bus.aw_addr = 32'h10; bus.w_valid = 1; bus.w_data = d2; bus.w_strb = 4'hF;
    step();
    bus.aw_addr = 32'h14; bus.w_valid = 0;
    repeat (6) begin
      tests++;
      if (bus.aw_ready !== 1'b0 || bus.b_valid !== 1'b1 || reg_q[4*DW +: DW] !== model[4]) begin
        fails++; $display("FAIL bstall_refuse: got awr=%b bv=%b reg4=%h expected 0 1 %h",
                          bus.aw_ready, bus.b_valid, reg_q[4*DW +: DW], model[4]);
      end
      step();
    end
    bus.aw_valid = 0;
    bus.b_ready = 1; step();
    tests++;
    if (bus.b_valid !== 1'b0) begin fails++; $display("FAIL bstall_b1_done: got %b expected 0", bus.b_valid); end
    step();
    model_write(32'h10, d2, 4'hF);
    tests++;
    if (bus.b_valid !== 1'b1 || reg_q[4*DW +: DW] !== model[4]) begin
      fails++; $display("FAIL bstall_second: got bv=%b reg4=%h expected 1 %h", bus.b_valid, reg_q[4*DW +: DW], model[4]);
    end
    step(); bus.b_ready = 0;
  endtask

  task automatic test_r_stall();
    logic [31:0] a1 = 4 * $urandom_range(0, NR-1), a2 = 4 * $urandom_range(0, NR-1);
    bus.r_ready = 0;
    bus.ar_valid = 1; bus.ar_addr = a1;
    step();
    bus.ar_addr = a2;
    repeat (5) begin
      tests++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== model_read(a1) || bus.ar_ready !== 1'b0) begin
        fails++; $display("FAIL rstall_hold: got rv=%b data=%h arr=%b expected 1 %h 0",
                          bus.r_valid, bus.r_data, bus.ar_ready, model_read(a1));
      end
      step();
    end
    bus.r_ready = 1; step();
    tests++;
    if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin
      fails++; $display("FAIL rstall_release: got rv=%b arr=%b expected 0 1", bus.r_valid, bus.ar_ready);
    end
    step();
    bus.ar_valid = 0;
    tests++;
    if (bus.r_valid !== 1'b1 || bus.r_data !== model_read(a2)) begin
      fails++; $display("FAIL rstall_second: got rv=%b data=%h expected 1 %h", bus.r_valid, bus.r_data, model_read(a2));
    end
    step(); bus.r_ready = 0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] data; resp_t resp; bit ok; int bad = 0;
    do_read(32'h40, data, resp, ok);
    tests++;
    if (!ok || data !== 32'h0 || resp !== OOR) begin
      fails++; $display("FAIL oor_read: got ok=%b data=%h resp=%0d expected 1 0 %0d", ok, data, resp, OOR);
    end
    do_write(32'h40, $urandom, 4'hF, resp, ok);
    tests++;
    if (!ok || resp !== OOR || pulse_seen !== '0) begin
      fails++; $display("FAIL oor_write: got ok=%b resp=%0d pulse=%h expected 1 %0d 0", ok, resp, pulse_seen, OOR);
    end
    for (int i = 0; i < NR; i++) if (reg_q[i*DW +: DW] !== model[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL oor_regs: got %0d changed regs expected 0", bad); end
  endtask

  task automatic test_strb_zero();
    logic [31:0] a = 4 * $urandom_range(0, NR-1); resp_t resp; bit ok;
    do_write(a, $urandom, 4'h0, resp, ok);
    tests++;
    if (!ok || resp !== RESP_OKAY || reg_q[(a/4)*DW +: DW] !== model[a/4] ||
        pulse_seen !== model_pulse(a) || pulse_cycles != 1) begin
      fails++; $display("FAIL strb_zero: got resp=%0d reg=%h pulse=%h x%0d expected 0 %h %h x1",
                        resp, reg_q[(a/4)*DW +: DW], pulse_seen, pulse_cycles, model[a/4], model_pulse(a));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [3:0] s; resp_t resp; bit ok; int bad = 0;
    repeat (60) begin
      a = 4 * $urandom_range(0, NR + 3) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, d, s, resp, ok);
        model_write(a, d, s);
        tests++;
        if (!ok || resp !== model_resp(a) || pulse_seen !== model_pulse(a) ||
            pulse_cycles != ((a / 4 < NR) ? 1 : 0)) begin
          fails++; $display("FAIL rand_write a=%h: got ok=%b resp=%0d pulse=%h x%0d expected 1 %0d %h",
                            a, ok, resp, pulse_seen, pulse_cycles, model_resp(a), model_pulse(a));
        end
      end else begin
        do_read(a, rd, resp, ok);
        tests++;
        if (!ok || rd !== model_read(a) || resp !== model_resp(a)) begin
          fails++; $display("FAIL rand_read a=%h: got ok=%b data=%h resp=%0d expected 1 %h %0d",
                            a, ok, rd, resp, model_read(a), model_resp(a));
        end
      end
    end
    for (int i = 0; i < NR; i++) if (reg_q[i*DW +: DW] !== model[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rand_regs: got %0d regs differing expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d = $urandom; resp_t resp; bit ok; bit b_seen = 0; int bad = 0;
    bus.b_ready = 0;
    bus.aw_valid = 1; bus.aw_addr = 32'h18; bus.w_valid = 1; bus.w_data = $urandom; bus.w_strb = 4'hF;
    step();
    bus.aw_valid = 0; bus.w_valid = 0;
    step();
    bus.aw_valid = 1; bus.aw_addr = 32'h1C;
    step();
    bus.aw_valid = 0;
    #2 rst = 1;
    #2 rst = 0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = RV;
    for (int i = 0; i < NR; i++) if (reg_q[i*DW +: DW] !== model[i]) bad++;
    tests++;
    if (bad != 0 || bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_state: got bad=%0d bv=%b awr=%b wr=%b expected 0 0 1 1",
                        bad, bus.b_valid, bus.aw_ready, bus.w_ready);
    end
    bus.b_ready = 1;
    repeat (6) begin step(); if (bus.b_valid) b_seen = 1; end
    bus.b_ready = 0;
    tests++;
    if (b_seen) begin fails++; $display("FAIL rstmid_no_b: got b_valid 1 expected 0"); end
    do_write(32'h1C, d, 4'hF, resp, ok);
    model_write(32'h1C, d, 4'hF);
    tests++;
    if (!ok || resp !== RESP_OKAY || reg_q[7*DW +: DW] !== model[7] || pulse_seen !== model_pulse(32'h1C)) begin
      fails++; $display("FAIL rstmid_write: got ok=%b resp=%0d reg7=%h pulse=%h expected 1 0 %h %h",
                        ok, resp, reg_q[7*DW +: DW], pulse_seen, model[7], model_pulse(32'h1C));
    end
  endtask

  initial begin
    bus.aw_valid = 0; bus.aw_addr = '0; bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0;
    bus.b_ready = 0; bus.ar_valid = 0; bus.ar_addr = '0; bus.r_ready = 0;
    pulse_seen = '0; pulse_cycles = 0;
    rst = 1;
    for (int i = 0; i < NR; i++) model[i] = RV;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    step();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_b_stall();
    test_r_stall();
    test_out_of_range();
    test_strb_zero();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameter NUM_REGS, default 16: number of DATA_WIDTH-bit registers; SHALL be 1..256.
REQ-002 Parameter RESET_VALUE, default 0: reset contents of every register, DATA_WIDTH bits.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high; the clk/rstn members of the interface SHALL be ignored.
REQ-005 Port master  axi_lite_channel.slave  (ADDR_WIDTH, DATA_WIDTH taken from the interface): AXI-Lite responder port.
REQ-006 Port reg_q  output  NUM_REGS*DATA_WIDTH: current register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port wr_pulse  output  NUM_REGS: one-cycle strobe, bit i high in the cycle after register i is written.

Function
REQ-008 Word index SHALL be addr >> log2(DATA_WIDTH/8); an index >= NUM_REGS is out of range.
REQ-009 aw_ready SHALL be high when no AW is held; an AW handshake captures addr into a one-entry hold register.
REQ-010 w_ready SHALL be high when no W is held; a W handshake captures data and strb into a one-entry hold register; AW and W SHALL be accepted in either order or in the same cycle.
REQ-011 Write commit SHALL occur in a cycle where AW and W are both held and b_valid is low; in that cycle the addressed register is updated byte-wise (byte k updated only if strb[k]), and both holds clear at the next edge.
REQ-012 b_valid SHALL rise on the edge ending the commit cycle and stay high with b_resp stable until b_ready; latency is 2 cycles from a same-cycle AW+W handshake to b_valid.
REQ-013 A commit with all strb bits zero SHALL leave the register unchanged, respond OKAY and still pulse wr_pulse.
REQ-014 ar_ready SHALL be high when r_valid is low; on an AR handshake r_data and r_resp are captured and r_valid rises on the next edge, held stable until r_ready.
REQ-015 Read data SHALL be the register value before any write committing in the same cycle as the AR handshake.
REQ-016 Read and write channels SHALL operate independently; neither blocks the other.
REQ-017 No valid output SHALL depend combinationally on any ready input.
REQ-018 In-range accesses SHALL respond OKAY (2'b00).

Reset
REQ-019 On rst: all registers = RESET_VALUE, holds empty, aw_ready = w_ready = ar_ready = 1 once rst deasserts, b_valid = r_valid = 0, b_resp = r_resp = OKAY, r_data = 0, wr_pulse = 0.
REQ-020 Reset asserted mid-transaction SHALL abandon all held and pending transactions without a response.

Configuration
REQ-021 With AXI_LITE_REGFILE_DECERR_EN defined: out-of-range writes are dropped with b_resp = DECERR (2'b11), and out-of-range reads return r_data = 0 with r_resp = DECERR; wr_pulse does not fire.
REQ-022 Without AXI_LITE_REGFILE_DECERR_EN: out-of-range writes are silently dropped with OKAY, and out-of-range reads return 0 with OKAY.

Structure
REQ-023 Response codes and resp_t SHALL come from the shared axi_common package; no new package entries other than a RESP_DECERR constant if it is absent.
REQ-024 Byte-strobe merge (old word, new word, strb -> merged word) SHALL be one sub-module, axi_lite_strb_merge; everything else is inline.

Verification
REQ-025 AW addr 0x8 and W 0xDEADBEEF/strb 0xF in the same cycle -> b_valid 2 cycles later with OKAY, reg_q[2] = 0xDEADBEEF, wr_pulse[2] for one cycle.
REQ-026 W 0x11223344/strb 0x5 three cycles before AW addr 0x0, with reg 0 initially 0 -> write waits for AW, reg_q[0] = 0x00220044, OKAY.
REQ-027 AR addr 0x8 while b_ready is held low for 10 cycles -> r_valid 1 cycle after AR with 0xDEADBEEF, and a second AW is refused until B completes.
REQ-028 AR addr 0x40 with NUM_REGS = 16 -> r_data 0, r_resp DECERR with the macro, OKAY without it; an AW/W to 0x40 leaves every register unchanged.
REQ-029 r_ready held low for 5 cycles -> r_valid and r_data stable, ar_ready low throughout, and the next AR is accepted only after the R handshake.
REQ-030 rst pulsed while AW is held and b_valid is high -> all registers = RESET_VALUE, b_valid = 0, no B is issued afterwards, and the next full write succeeds normally.
